// File: rtl/counter_frequency_div_prog.sv
// Runtime-programmable clock-enable divider: one-cycle tick every N enabled cycles,
// glitch-free divisor reload at period boundaries. Define CLKDIV_SQUARE_OUT_EN for the square-wave output.
module counter_frequency_div_prog #(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_load,
    output logic             div_busy,
    output logic             div_err,
    output logic             tick,
    output logic             out,
    output logic [WIDTH-1:0] count
);

    generate
        if (DEFAULT_DIV < 1 || longint'(DEFAULT_DIV) > ((longint'(1) << WIDTH) - 1)) begin : g_bad_default
            $error("DEFAULT_DIV must be in 1 .. 2**WIDTH-1");
        end
    endgenerate

    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);

    logic [WIDTH-1:0] div_cur_q, div_cur_d;
    logic [WIDTH-1:0] div_pend_q, div_pend_d;
    logic             pend_v_q, pend_v_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tick_q, tick_d;
    logic             err_q, err_d;

    logic             load_ok, wrap, apply;
    logic [WIDTH-1:0] nxt_div;

    // A load on the applying edge bypasses the pending register.
    assign load_ok = div_load && (div_in != '0);
    assign wrap    = en && (count_q == div_cur_q - 1'b1);
    assign nxt_div = load_ok ? div_in : div_pend_q;
    assign apply   = (load_ok || pend_v_q) && (wrap || !en);

    always_comb begin
        div_cur_d  = div_cur_q;
        div_pend_d = div_pend_q;
        pend_v_d   = pend_v_q;
        count_d    = count_q;
        tick_d     = 1'b0;
        err_d      = div_load && (div_in == '0);

        if (load_ok) begin
            div_pend_d = div_in;
            pend_v_d   = 1'b1;
        end

        if (en) begin
            count_d = wrap ? '0 : count_q + 1'b1;
            tick_d  = wrap;
        end

        if (apply) begin
            div_cur_d = nxt_div;
            pend_v_d  = 1'b0;
            count_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cur_q  <= DEF_DIV;
            div_pend_q <= '0;
            pend_v_q   <= 1'b0;
            count_q    <= '0;
            tick_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            div_cur_q  <= div_cur_d;
            div_pend_q <= div_pend_d;
            pend_v_q   <= pend_v_d;
            count_q    <= count_d;
            tick_q     <= tick_d;
            err_q      <= err_d;
        end
    end

`ifdef CLKDIV_SQUARE_OUT_EN
    logic             out_q, out_d;
    logic [WIDTH:0]   half_div;

    // ceil(N/2) in WIDTH+1 bits so N = 2**WIDTH-1 cannot overflow.
    assign half_div = ({1'b0, div_cur_q} + (WIDTH+1)'(1)) >> 1;

    always_comb begin
        out_d = out_q;
        if (en) begin
            out_d = ({1'b0, count_d} < half_div);
        end else if (apply) begin
            out_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q <= 1'b0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;
`else
    assign out = 1'b0;
`endif

    assign div_busy = pend_v_q;
    assign div_err  = err_q;
    assign tick     = tick_q;
    assign count    = count_q;

endmodule

// File: doc/counter_frequency_div_prog.md
# counter_frequency_div_prog

Runtime-programmable clock-enable divider: the parametrised successor of the fixed divide-by-100 counter. It produces a one-cycle `tick` every N enabled `clk` cycles and, optionally, a near-50 % square wave `out`. The divisor N can be reloaded glitch-free while running. It sits between the board clock and the microwave timer, display-scan and buzzer logic, which each use their own instance with a different N.

## Interface
- `WIDTH`, default 16: width of the counter and the divisor.
- `DEFAULT_DIV`, default 100: divisor loaded at reset. Must satisfy 1 ≤ `DEFAULT_DIV` ≤ 2^`WIDTH`−1; violating this is an elaboration error.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `en`  in  1  count enable; when low, `count`, `tick`-generation and `out` hold.
- `div_in`  in  `WIDTH`  new divisor value.
- `div_load`  in  1  one-cycle request to load `div_in`.
- `div_busy`  out  1  a load is pending and not yet applied.
- `div_err`  out  1  one-cycle pulse: a load was rejected.
- `tick`  out  1  one-cycle pulse per completed period.
- `out`  out  1  square wave, period N.
- `count`  out  `WIDTH`  current count, 0..N−1.

## Operation
- Registers:
  - `div_cur`: active N.
  - `div_pend` plus `pend_v`: pending load.
  - `count`.
  - Registered `tick`, `out` and `div_err`.
- **Reset** (`rst_n`=0 at an edge): `div_cur`=`DEFAULT_DIV`, `count`=0, `pend_v`=0, `tick`=0, `out`=0, `div_err`=0, `div_busy`=0. Reset overrides every other input, including a pending load, which is discarded.
- **Counting**, on an edge with `en`=1:
  - If `count`==`div_cur`−1 (wrap), then `count`←0 and `tick`←1.
  - Otherwise `count`←`count`+1 and `tick`←0.
- **Counting**, on an edge with `en`=0: `count` holds and `tick`←0.
- **Square wave:** on each enabled edge, `out`←(next `count` < ceil(`div_cur`/2)), where ceil(N/2) = (N+1)>>1 computed in `WIDTH`+1 bits. `out` holds when `en`=0. With N=1, `out` stays 1 after the first enabled edge.
- **Load, rejected case:** `div_load`=1 with `div_in`==0 is rejected. `div_err`←1 for one cycle, and the pending state is unchanged.
- **Load, accepted case** (`div_in` ≥ 1): `div_pend`←`div_in` and `pend_v`←1. A later load overwrites a still-pending value; last writer wins.
- **Apply:** a pending value is applied on the first edge where either of these holds:
  - a wrap occurs: `div_cur`←`div_pend`, `count`←0, `tick`←1;
  - `en`=0: `div_cur`←`div_pend`, `count`←0, `out`←0, no tick.
- **Load arriving on an apply edge:**
  - A load whose `div_load` edge coincides with a wrap edge is applied at that same wrap, bypassing `div_pend`.
  - A load whose `div_load` edge has `en`=0 is likewise applied immediately.
- Because loads apply only at period boundaries, no runt or stretched period is ever produced while running.
- `div_busy` = `pend_v`. It is high from the cycle after an accepted load through the cycle of the applying edge, and is 0 after it.

## Timing
- Steady state with `en`=1 and divisor N: `tick` is high for exactly one cycle every N cycles.
- First `tick` after reset release: high in the cycle following the N-th enabled edge.
- `out` is high for ceil(N/2) cycles and low for floor(N/2) cycles per period, and rises in the same cycle as `tick`.
- Load latency: at most N cycles when running; one edge when `en`=0.
- All outputs are registered. There are no combinational paths from input to output.
- When `en` toggles, the period simply stretches by the number of disabled cycles, and no count is lost.

## Configuration
- `CLKDIV_SQUARE_OUT_EN` defined: the `out` register and its ceil(N/2) comparator are compiled in, behaving as above.
- Not defined: `out` is tied constant 0 and the comparator and register are removed. `tick`, `count` and the load logic are unchanged.

## Test plan
- Reset, then `en`=1 with default N=100 for 1000 cycles → exactly 10 `tick` pulses, spaced 100 cycles apart. The first is the cycle after edge 100. `out` is high for 50 cycles and low for 50.
- N=7 loaded with `en`=0 → applied next edge and `count`=0. Running then gives a tick every 7 cycles, with `out` high 4 cycles and low 3.
- While running N=100, load 10 at `count`=37 → `div_busy` is high until the wrap at `count`=99. The next period is 10 cycles, with no short period.
- Load 5 then load 9 within one period → only 9 is applied at the wrap. Loading `div_in`=0 → one-cycle `div_err`, with the divisor and `div_busy` unchanged.
- Pulse `rst_n`=0 for one edge mid-period while a load is pending → `count`=0, `div_busy`=0, and N returns to 100.
- Build without `CLKDIV_SQUARE_OUT_EN` → `out`≡0, and tick spacing is identical to the first scenario.
